// File: rtl/axa_add_sequencer_pkg.sv
// Shared definitions for the 2x2 matrix-add sequencer: FSM states,
// element index constants, the quiet-NaN fill value and the default width.
package axa_add_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Element order matches issue order: row-major C11, C12, C21, C22.
    localparam logic [1:0] IDX_C11 = 2'd0;
    localparam logic [1:0] IDX_C12 = 2'd1;
    localparam logic [1:0] IDX_C21 = 2'd2;
    localparam logic [1:0] IDX_C22 = 2'd3;

    // Written into an element whose addition never completed.
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/axa_add_sequencer_add_watchdog.sv
// Per-element wait watchdog for the matrix-add sequencer.
// Counts enabled cycles since the last clear; expired_o goes high (registered)
// once the count has reached TIMEOUT_CYCLES and stays high until cleared.
// Only instantiated when ADDER_TIMEOUT_EN is defined.
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-high reset
//   clear_i   in   restart the count (held while not waiting)
//   en_i      in   count this cycle
//   expired_o out  limit reached
module axa_add_sequencer_add_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // Count up while enabled; freeze once expired so the counter cannot wrap.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (clear_i) begin
            cnt_d     = '0;
            expired_d = 1'b0;
        end else if (en_i && !expired_q) begin
            cnt_d     = cnt_q + CNT_W'(1);
            expired_d = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/axa_add_sequencer.sv
// 2x2 single-precision matrix add C = A + B sequenced through one shared
// scalar adder. A/B are latched on Start, the four element sums are issued
// in order C11, C12, C21, C22, and the result is held with Stable until Ack.
// Optional build macro ADDER_TIMEOUT_EN adds a per-element watchdog that
// fills a stalled element with qNaN and raises a sticky Error.
//   input_Clk, input_Reset         clock / synchronous active-high reset
//   input_Start, input_C_Ack       request (IDLE only) / result acknowledge (DONE only)
//   input_A11..A22, input_B11..B22 operand matrices
//   output_Add_A/B, output_Add_Start  operands and issue pulse to the adder
//   input_Add_Done, input_Add_Sum  adder result-valid pulse and result
//   output_Stable, output_C11..C22 result valid and result elements
//   output_Error                   sticky watchdog error (0 without the macro)
module axa_add_sequencer
    import axa_add_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             input_Clk,
    input  logic             input_Reset,
    input  logic             input_Start,
    input  logic             input_C_Ack,
    input  logic [WIDTH-1:0] input_A11,
    input  logic [WIDTH-1:0] input_A12,
    input  logic [WIDTH-1:0] input_A21,
    input  logic [WIDTH-1:0] input_A22,
    input  logic [WIDTH-1:0] input_B11,
    input  logic [WIDTH-1:0] input_B12,
    input  logic [WIDTH-1:0] input_B21,
    input  logic [WIDTH-1:0] input_B22,
    output logic [WIDTH-1:0] output_Add_A,
    output logic [WIDTH-1:0] output_Add_B,
    output logic             output_Add_Start,
    input  logic             input_Add_Done,
    input  logic [WIDTH-1:0] input_Add_Sum,
    output logic             output_Stable,
    output logic [WIDTH-1:0] output_C11,
    output logic [WIDTH-1:0] output_C12,
    output logic [WIDTH-1:0] output_C21,
    output logic [WIDTH-1:0] output_C22,
    output logic             output_Error
);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0][WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [WIDTH-1:0]      add_a_q, add_a_d, add_b_q, add_b_d;
    logic                  add_start_q, add_start_d;
    logic                  stable_q, stable_d;
    logic                  error_q, error_d;
    logic                  timeout_c;

`ifdef ADDER_TIMEOUT_EN
    logic wd_expired;

    // Held clear outside WAIT, so every entry to WAIT starts from zero.
    axa_add_sequencer_add_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_add_watchdog (
        .clk_i     (input_Clk),
        .rst_i     (input_Reset),
        .clear_i   (state_q != ST_WAIT),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wd_expired)
    );

    assign timeout_c = wd_expired;
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
    assign timeout_c = 1'b0;
`endif

    // Next state, operand latch and per-element result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        error_d = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (input_Start) begin
                    a_d     = {input_A22, input_A21, input_A12, input_A11};
                    b_d     = {input_B22, input_B21, input_B12, input_B11};
                    idx_d   = IDX_C11;
                    error_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A real Done wins over a timeout landing in the same cycle.
                if (input_Add_Done || timeout_c) begin
                    c_d[idx_q] = input_Add_Done ? input_Add_Sum : WIDTH'(QNAN);
                    if (!input_Add_Done) begin
                        error_d = 1'b1;
                    end
                    if (idx_q == IDX_C22) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (input_C_Ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        add_start_d = (state_d == ST_ISSUE);
        stable_d    = (state_d == ST_DONE);
        add_a_d     = add_start_d ? a_d[idx_d] : add_a_q;
        add_b_d     = add_start_d ? b_d[idx_d] : add_b_q;
    end

    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_C11;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_start_q <= 1'b0;
            stable_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_start_q <= add_start_d;
            stable_q    <= stable_d;
            error_q     <= error_d;
        end
    end

    assign output_Add_A     = add_a_q;
    assign output_Add_B     = add_b_q;
    assign output_Add_Start = add_start_q;
    assign output_Stable    = stable_q;
    assign output_C11       = c_q[IDX_C11];
    assign output_C12       = c_q[IDX_C12];
    assign output_C21       = c_q[IDX_C21];
    assign output_C22       = c_q[IDX_C22];
    assign output_Error     = error_q;

endmodule

// File: tb/tb_axa_add_sequencer.sv
// Self-checking bench for axa_add_sequencer: a behavioural scalar adder with
// configurable latency answers the issue pulses, and expected results come
// from real-valued A+B and the cycle formula 4*(1+L)+1.
module tb_axa_add_sequencer;

    localparam logic [31:0] QNAN_BITS = 32'h7FC0_0000;
    typedef logic [31:0] quad_t [4];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, ack;
    logic [31:0] a_in [4];
    logic [31:0] b_in [4];
    logic [31:0] add_a, add_b, add_sum;
    logic        add_start, add_done, stable, err;
    logic [31:0] c_out [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural adder: answers L cycles after the issue pulse, or never
    // for element drop_idx.
    int          lat      = 3;
    int          drop_idx = -1;
    int          cd       = 0;
    logic [31:0] pend     = '0;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_sum  = '0;
    logic        inj_done = 1'b0;
    logic [31:0] inj_sum  = '0;
    logic [31:0] iss_a [$];
    logic [31:0] iss_b [$];

    assign add_done = mdl_done | inj_done;
    assign add_sum  = inj_done ? inj_sum : mdl_sum;

    axa_add_sequencer #(
        .WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .input_Clk        (clk),
        .input_Reset      (rst),
        .input_Start      (start),
        .input_C_Ack      (ack),
        .input_A11        (a_in[0]),
        .input_A12        (a_in[1]),
        .input_A21        (a_in[2]),
        .input_A22        (a_in[3]),
        .input_B11        (b_in[0]),
        .input_B12        (b_in[1]),
        .input_B21        (b_in[2]),
        .input_B22        (b_in[3]),
        .output_Add_A     (add_a),
        .output_Add_B     (add_b),
        .output_Add_Start (add_start),
        .input_Add_Done   (add_done),
        .input_Add_Sum    (add_sum),
        .output_Stable    (stable),
        .output_C11       (c_out[0]),
        .output_C12       (c_out[1]),
        .output_C21       (c_out[2]),
        .output_C22       (c_out[3]),
        .output_Error     (err)
    );

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return r2sp(sp2r(x) + sp2r(y));
    endfunction

    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mdl_done = 1'b1;
                    mdl_sum  = pend;
                end
            end
            if (add_start) begin
                if (iss_a.size() != drop_idx) begin
                    pend = fadd(add_a, add_b);
                    cd   = lat;
                end
                iss_a.push_back(add_a);
                iss_b.push_back(add_b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stable(output int n);
        n = 0;
        while (!stable && n < 500) begin
            cyc();
            n++;
        end
        check("stable_rise", 32'(stable), 32'd1);
    endtask

    task automatic check_results(input string tag, input quad_t ea, input quad_t eb);
        check({tag, "_issues"}, 32'(iss_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_a.size()) begin
                check($sformatf("%s_iss_a%0d", tag, i), iss_a[i], ea[i]);
                check($sformatf("%s_iss_b%0d", tag, i), iss_b[i], eb[i]);
            end
            check($sformatf("%s_c%0d", tag, i), c_out[i],
                  (i == drop_idx) ? QNAN_BITS : fadd(ea[i], eb[i]));
        end
    endtask

    // One full operation with a single-cycle Start pulse; inputs are
    // scrambled right after the latch to prove they are not resampled.
    task automatic do_op(input quad_t ea, input quad_t eb, input bit chk_lat, input string tag);
        int n;
        iss_a.delete();
        iss_b.delete();
        for (int i = 0; i < 4; i++) begin
            a_in[i] = ea[i];
            b_in[i] = eb[i];
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            a_in[i] = $urandom;
            b_in[i] = $urandom;
        end
        wait_stable(n);
        // The Start cycle itself counts as the first cycle.
        if (chk_lat) check({tag, "_lat"}, 32'(n + 1), 32'(4 * (1 + lat) + 1));
        check_results(tag, ea, eb);
    endtask

    task automatic ack_op(input string tag);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        check({tag, "_stable_off"}, 32'(stable), 32'd0);
    endtask

    task automatic rand_quad(output quad_t q);
        for (int i = 0; i < 4; i++) q[i] = r2sp(real'($urandom_range(0, 1000)));
    endtask

    initial begin
        quad_t ea, eb, ea2, eb2, saved;
        int    n, starts;

        rst   = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        repeat (3) cyc();
        rst = 1'b0;
        check("rst_stable", 32'(stable), 32'd0);
        check("rst_add_start", 32'(add_start), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_c%0d", i), c_out[i], 32'd0);

        // Scenario 1: basic operation with fixed operands.
        ea = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h42FA0000};
        eb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000};
        do_op(ea, eb, 1'b1, "t1");
        check("t1_c11_const", c_out[0], 32'h40000000);
        check("t1_c12_const", c_out[1], 32'h40400000);
        check("t1_c21_const", c_out[2], 32'h40800000);
        check("t1_c22_const", c_out[3], 32'h42FA0000);

        // Scenario 2: hold without Ack while Start toggles and A changes.
        saved  = c_out;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            start   = i[0];
            a_in[0] = $urandom;
            cyc();
            if (add_start) starts++;
            check("t2_stable_hold", 32'(stable), 32'd1);
        end
        start = 1'b0;
        check("t2_no_issue", 32'(starts), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("t2_c%0d_hold", i), c_out[i], saved[i]);
        ack_op("t2");

        // Scenario 6a: stray Done and Ack while idle.
        saved    = c_out;
        inj_sum  = 32'hDEADBEEF;
        inj_done = 1'b1;
        ack      = 1'b1;
        cyc();
        inj_done = 1'b0;
        ack      = 1'b0;
        cyc();
        check("t6_idle_stable", 32'(stable), 32'd0);
        check("t6_idle_issue", 32'(add_start), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("t6_idle_c%0d", i), c_out[i], saved[i]);

        // Scenario 6b: Done during ISSUE and Ack during ISSUE/WAIT are ignored.
        rand_quad(ea);
        rand_quad(eb);
        iss_a.delete();
        iss_b.delete();
        for (int i = 0; i < 4; i++) begin
            a_in[i] = ea[i];
            b_in[i] = eb[i];
        end
        start = 1'b1;
        cyc();
        start    = 1'b0;
        inj_done = 1'b1;
        ack      = 1'b1;
        cyc();
        inj_done = 1'b0;
        cyc();
        ack = 1'b0;
        wait_stable(n);
        check("t6_lat", 32'(n + 3), 32'(4 * (1 + lat) + 1));
        check_results("t6", ea, eb);
        ack_op("t6");

        // Scenario 3: Start held high; Ack in DONE, new op from IDLE-cycle inputs.
        rand_quad(ea);
        rand_quad(eb);
        do_op(ea, eb, 1'b1, "t3a");
        start = 1'b1;
        ack   = 1'b1;
        cyc();
        check("t3_idle_stable", 32'(stable), 32'd0);
        check("t3_idle_issue", 32'(add_start), 32'd0);
        rand_quad(ea2);
        rand_quad(eb2);
        iss_a.delete();
        iss_b.delete();
        for (int i = 0; i < 4; i++) begin
            a_in[i] = ea2[i];
            b_in[i] = eb2[i];
        end
        ack = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            a_in[i] = $urandom;
            b_in[i] = $urandom;
        end
        check("t3_restart_issue", 32'(add_start), 32'd1);
        check("t3_restart_a", add_a, ea2[0]);
        wait_stable(n);
        check("t3_lat", 32'(n + 1), 32'(4 * (1 + lat) + 1));
        check_results("t3b", ea2, eb2);
        start = 1'b0;
        ack_op("t3");

        // Scenario 4: reset while waiting on C12, then a late Done.
        rand_quad(ea);
        rand_quad(eb);
        iss_a.delete();
        iss_b.delete();
        for (int i = 0; i < 4; i++) begin
            a_in[i] = ea[i];
            b_in[i] = eb[i];
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (iss_a.size() < 2 && n < 100) begin
            cyc();
            n++;
        end
        check("t4_reached_c12", 32'(iss_a.size()), 32'd2);
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        inj_sum  = 32'hDEADBEEF;
        inj_done = 1'b1;
        check("t4_stable", 32'(stable), 32'd0);
        check("t4_add_start", 32'(add_start), 32'd0);
        check("t4_add_a", add_a, 32'd0);
        check("t4_add_b", add_b, 32'd0);
        check("t4_err", 32'(err), 32'd0);
        cyc();
        inj_done = 1'b0;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (stable || add_start) starts++;
        end
        check("t4_stays_idle", 32'(starts), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("t4_c%0d", i), c_out[i], 32'd0);

`ifdef ADDER_TIMEOUT_EN
        // Scenario 5: adder never answers C21; watchdog fills qNaN.
        rand_quad(ea);
        rand_quad(eb);
        drop_idx = 2;
        do_op(ea, eb, 1'b0, "t5");
        check("t5_err_set", 32'(err), 32'd1);
        ack_op("t5");
        drop_idx = -1;
        check("t5_err_sticky", 32'(err), 32'd1);
        rand_quad(ea);
        rand_quad(eb);
        do_op(ea, eb, 1'b1, "t5b");
        ack_op("t5b");
`endif

        // Randomized operations with varying adder latency and Ack delay.
        for (int k = 0; k < 8; k++) begin
            lat = $urandom_range(1, 5);
            rand_quad(ea);
            rand_quad(eb);
            do_op(ea, eb, 1'b1, $sformatf("rnd%0d", k));
            repeat ($urandom_range(0, 3)) begin
                cyc();
                check("rnd_hold", 32'(stable), 32'd1);
            end
            ack_op("rnd");
        end

`ifndef ADDER_TIMEOUT_EN
        check("err_tied", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
